// File: rtl/datagram_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : datagram_packer_pkg
// Brief    : Shared widths, scene codes and the AlienData record for the packer.
// Revision : 1.0 - initial release
// ============================================================================
package datagram_packer_pkg;

  localparam int STATE_SIZE           = 3;
  localparam int LEVEL_SIZE           = 4;
  localparam int SCORE_SIZE           = 16;
  localparam int SCOREBOARD_DATA_SIZE = 12;
  localparam int OBJ_LIMIT            = 8;
  localparam int LASER_SIZE           = 14;
  localparam int ALIEN_SIZE           = 35;
  localparam int FRAME_DATA_SIZE      = LASER_SIZE + ALIEN_SIZE * OBJ_LIMIT;
  localparam int MESSAGE_SIZE         = STATE_SIZE + LEVEL_SIZE + SCORE_SIZE + FRAME_DATA_SIZE;

  localparam logic [STATE_SIZE-1:0] SCENE_TITLE      = STATE_SIZE'(0);
  localparam logic [STATE_SIZE-1:0] SCENE_PLAY       = STATE_SIZE'(1);
  localparam logic [STATE_SIZE-1:0] SCENE_SCOREBOARD = STATE_SIZE'(2);
  localparam logic [STATE_SIZE-1:0] SCENE_GAME_OVER  = STATE_SIZE'(3);

  // Declared MSB first so the packed bits match the slot layout LSB first
  typedef struct packed {
    logic [1:0] _deriv_right;
    logic [1:0] _deriv_left;
    logic [9:0] _y_pos;
    logic [9:0] _x_pos;
    logic [1:0] _quadrant;
    logic [3:0] _r;
    logic [1:0] _frame_num;
    logic [1:0] _type;
    logic       _active;
  } AlienData;

  function automatic logic [LASER_SIZE-1:0] pack_laser(input logic       active,
                                                       input logic [3:0] r,
                                                       input logic [8:0] deg);
    return {deg, r, active};
  endfunction

endpackage
`default_nettype wire

// File: rtl/datagram_packer_sorted_insert_list.sv
`default_nettype none
// ============================================================================
// Module   : sorted_insert_list
// Brief    : Record list with clear, single-cycle insert and parallel read.
//            DATAGRAM_SORT_EN: stable ascending-_r insertion, else append.
// Revision : 1.0 - initial release
// ============================================================================
module sorted_insert_list
  import datagram_packer_pkg::*;
#(
  parameter int SLOTS = OBJ_LIMIT,
  parameter int CW    = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          insert,
  input  AlienData      rec,
  output AlienData      entries [SLOTS],
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] c_slots = CW'(SLOTS);

  AlienData      r_entries [SLOTS];
  AlienData      w_prev    [SLOTS];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_pos;
  logic          w_accept;

  assign w_accept = insert && (r_count < c_slots);

`ifdef DATAGRAM_SORT_EN
  // First occupied slot holding a strictly larger _r; equal keys stay ahead
  always_comb begin
    w_pos = r_count;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((CW'(i) < r_count) && (rec._r < r_entries[i]._r)) w_pos = CW'(i);
    end
  end
`else
  assign w_pos = r_count;
`endif

  always_comb begin
    w_prev[0] = '0;
    for (int i = 1; i < SLOTS; i++) w_prev[i] = r_entries[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < SLOTS; i++) r_entries[i] <= '0;
    end else if (clear) begin
      r_count <= '0;
      for (int i = 0; i < SLOTS; i++) r_entries[i] <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
        if (CW'(i) == w_pos)     r_entries[i] <= rec;
        else if (CW'(i) > w_pos) r_entries[i] <= w_prev[i];
      end
    end
  end

  assign entries = r_entries;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/datagram_packer.sv
`default_nettype none
// ============================================================================
// Module   : datagram_packer
// Brief    : Collects alien records per frame and publishes a packed datagram.
//            DATAGRAM_SORT_EN selects sorted insertion in the record list.
// Revision : 1.0 - initial release
// ============================================================================
module datagram_packer
  import datagram_packer_pkg::*;
#(
  parameter int SLOTS = OBJ_LIMIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STATE_SIZE-1:0]           core_state,
  input  logic [SCORE_SIZE-1:0]           score,
  input  logic [LEVEL_SIZE-1:0]           level,
  input  logic                            laser_active,
  input  logic [3:0]                      laser_r,
  input  logic [8:0]                      laser_deg,
  input  logic [SCOREBOARD_DATA_SIZE-1:0] scoreboard_data,
  input  logic                            frame_start,
  input  logic                            frame_end,
  input  logic                            rec_valid,
  output logic                            rec_ready,
  input  AlienData                        rec,
  output logic [MESSAGE_SIZE-1:0]         datagram,
  output logic                            dgram_update,
  output logic                            overflow
);

  localparam int            CW      = $clog2(SLOTS + 1);
  localparam logic [CW-1:0] c_slots = CW'(SLOTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  AlienData                        w_entries [SLOTS];
  logic [CW-1:0]                   w_count;
  logic                            w_insert;
  logic [FRAME_DATA_SIZE-1:0]      w_commit_data;
  logic [FRAME_DATA_SIZE-1:0]      r_frame_data;
  logic [SCORE_SIZE-1:0]           r_score;
  logic [LEVEL_SIZE-1:0]           r_level;
  logic [STATE_SIZE-1:0]           r_scene;
  logic [SCOREBOARD_DATA_SIZE-1:0] r_sb_data;
  logic                            r_dgram_update;
  logic                            r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = IDLE;
      COLLECT: if (frame_end) w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (frame_start) w_next_state = COLLECT;
  end

  assign rec_ready = (r_state == COLLECT) && (w_count < c_slots);
  // Inactive records complete the handshake but never enter the list
  assign w_insert  = rec_valid && rec_ready && rec._active && !frame_start;

  sorted_insert_list #(
    .SLOTS (SLOTS),
    .CW    (CW)
  ) u_list (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_start),
    .insert  (w_insert),
    .rec     (rec),
    .entries (w_entries),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (frame_start) begin
      r_overflow <= 1'b0;
    end else if ((r_state == COLLECT) && (w_count == c_slots) && rec_valid && rec._active) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_commit_data[LASER_SIZE-1:0] = pack_laser(laser_active, laser_r, laser_deg);

  for (genvar k = 0; k < OBJ_LIMIT; k++) begin : g_slot
    if (k < SLOTS) begin : g_used
      assign w_commit_data[LASER_SIZE + ALIEN_SIZE*k +: ALIEN_SIZE] = w_entries[k];
    end else begin : g_pad
      assign w_commit_data[LASER_SIZE + ALIEN_SIZE*k +: ALIEN_SIZE] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scene        <= '0;
      r_sb_data      <= '0;
      r_level        <= '0;
      r_score        <= '0;
      r_frame_data   <= '0;
      r_dgram_update <= 1'b0;
    end else begin
      r_scene        <= core_state;
      r_sb_data      <= scoreboard_data;
      r_dgram_update <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_level      <= level;
        r_score      <= score;
        r_frame_data <= w_commit_data;
      end
    end
  end

  // Scoreboard scene overlays the payload; the committed frame copy is kept intact
  always_comb begin
    datagram                   = '0;
    datagram[STATE_SIZE-1:0]   = r_scene;
    if (r_scene == SCENE_SCOREBOARD)
      datagram[STATE_SIZE +: SCOREBOARD_DATA_SIZE] = r_sb_data;
    else
      datagram[MESSAGE_SIZE-1:STATE_SIZE] = {r_frame_data, r_score, r_level};
  end

  assign dgram_update = r_dgram_update;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_datagram_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_datagram_packer
// Brief    : Random and directed frames against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datagram_packer;
  import datagram_packer_pkg::*;

  localparam int SLOTS = OBJ_LIMIT;
  localparam int SLOT0 = STATE_SIZE + LEVEL_SIZE + SCORE_SIZE + 14;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [STATE_SIZE-1:0]           core_state;
  logic [SCORE_SIZE-1:0]           score;
  logic [LEVEL_SIZE-1:0]           level;
  logic                            laser_active;
  logic [3:0]                      laser_r;
  logic [8:0]                      laser_deg;
  logic [SCOREBOARD_DATA_SIZE-1:0] scoreboard_data;
  logic                            frame_start;
  logic                            frame_end;
  logic                            rec_valid;
  logic                            rec_ready;
  AlienData                        rec;
  logic [MESSAGE_SIZE-1:0]         datagram;
  logic                            dgram_update;
  logic                            overflow;

  datagram_packer #(.SLOTS(SLOTS)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_state      (core_state),
    .score           (score),
    .level           (level),
    .laser_active    (laser_active),
    .laser_r         (laser_r),
    .laser_deg       (laser_deg),
    .scoreboard_data (scoreboard_data),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec             (rec),
    .datagram        (datagram),
    .dgram_update    (dgram_update),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MESSAGE_SIZE-1:0] msg;
    int                      due;
  } exp_t;

  exp_t                    exp_q[$];
  exp_t                    mon_e;
  AlienData                arrivals[$];
  int                      total = 0;
  int                      bad = 0;
  int                      cyc = 0;
  int                      pulses = 0;
  bit                      m_collect = 0;
  bit                      m_ovf = 0;
  logic [MESSAGE_SIZE-1:0] last_msg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [MESSAGE_SIZE-1:0] act,
                       input logic [MESSAGE_SIZE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: stable sort by _r (or arrival order), fields placed per slot layout
  function automatic logic [MESSAGE_SIZE-1:0] expect_msg(input AlienData recs[$]);
    logic [MESSAGE_SIZE-1:0] m;
    AlienData                ord[$];
    int                      b;
    m = '0;
`ifdef DATAGRAM_SORT_EN
    for (int v = 0; v < 16; v++)
      foreach (recs[j]) if (int'(recs[j]._r) == v) ord.push_back(recs[j]);
`else
    ord = recs;
`endif
    m[0 +: STATE_SIZE] = core_state;
    m[STATE_SIZE +: LEVEL_SIZE] = level;
    m[STATE_SIZE + LEVEL_SIZE +: SCORE_SIZE] = score;
    b = STATE_SIZE + LEVEL_SIZE + SCORE_SIZE;
    m[b] = laser_active;
    m[b+1 +: 4] = laser_r;
    m[b+5 +: 9] = laser_deg;
    foreach (ord[k]) begin
      int s;
      s = b + 14 + 35 * k;
      m[s]        = ord[k]._active;
      m[s+1 +: 2] = ord[k]._type;
      m[s+3 +: 2] = ord[k]._frame_num;
      m[s+5 +: 4] = ord[k]._r;
      m[s+9 +: 2] = ord[k]._quadrant;
      m[s+11 +: 10] = ord[k]._x_pos;
      m[s+21 +: 10] = ord[k]._y_pos;
      m[s+31 +: 2] = ord[k]._deriv_left;
      m[s+33 +: 2] = ord[k]._deriv_right;
    end
    return m;
  endfunction

  function automatic AlienData rand_rec(input bit act);
    logic [63:0] t;
    AlienData    a;
    t = {$urandom, $urandom};
    a = t[34:0];
    a._active = act;
    return a;
  endfunction

  function automatic AlienData mk(input logic [3:0] r, input logic [9:0] x);
    AlienData a;
    a = '0;
    a._active = 1'b1;
    a._r = r;
    a._x_pos = x;
    return a;
  endfunction

  function automatic logic [3:0] slot_r(input int k);
    return datagram[SLOT0 + 35*k + 5 +: 4];
  endfunction

  task automatic rand_scalars();
    level = LEVEL_SIZE'($urandom);
    score = SCORE_SIZE'($urandom);
    laser_active = 1'($urandom);
    laser_r = 4'($urandom);
    laser_deg = 9'($urandom);
  endtask

  // One clock of stimulus; model steps with what the DUT sees at the next edge
  task automatic drive_cycle(input bit fs, input bit fe, input bit rv, input AlienData r);
    bit exp_ready;
    frame_start = fs;
    frame_end = fe;
    rec_valid = rv;
    rec = r;
    @(negedge clk);
    exp_ready = m_collect && (arrivals.size() < SLOTS);
    check("rec_ready", MESSAGE_SIZE'(rec_ready), MESSAGE_SIZE'(exp_ready));
    check("overflow", MESSAGE_SIZE'(overflow), MESSAGE_SIZE'(m_ovf));
    if (fs) begin
      arrivals.delete();
      m_ovf = 0;
      m_collect = 1;
    end else if (m_collect) begin
      if (rv && r._active) begin
        if (exp_ready) arrivals.push_back(r);
        else m_ovf = 1;
      end
      if (fe) begin
        exp_t e;
        e.msg = expect_msg(arrivals);
        e.due = cyc + 2;
        exp_q.push_back(e);
        m_collect = 0;
      end
    end
    @(posedge clk);
    #1;
    frame_start = 0;
    frame_end = 0;
    rec_valid = 0;
    rec = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (dgram_update) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dgram_update: unexpected pulse at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_cycle", MESSAGE_SIZE'(cyc), MESSAGE_SIZE'(mon_e.due));
        check("datagram", datagram, mon_e.msg);
        last_msg = mon_e.msg;
      end
    end
  end

  initial begin
    logic [3:0] exp_r[4];
    int         b_slot;
    rst = 1'b0;
    core_state = SCENE_TITLE;
    scoreboard_data = '0;
    frame_start = 0;
    frame_end = 0;
    rec_valid = 0;
    rec = '0;
    rand_scalars();
    repeat (2) @(negedge clk);
    check("reset_datagram", datagram, '0);
    check("reset_update", MESSAGE_SIZE'(dgram_update), '0);
    check("reset_ready", MESSAGE_SIZE'(rec_ready), '0);
    check("reset_overflow", MESSAGE_SIZE'(overflow), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Directed ordering frame: r = 9, 3, 12, 3(B)
    rand_scalars();
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 0, 1, mk(4'd9, 10'd1));
    drive_cycle(0, 0, 1, mk(4'd3, 10'd1));
    drive_cycle(0, 0, 1, mk(4'd12, 10'd1));
    drive_cycle(0, 0, 1, mk(4'd3, 10'd2));
    drive_cycle(0, 1, 0, '0);
    idle(4);
`ifdef DATAGRAM_SORT_EN
    exp_r = '{4'd3, 4'd3, 4'd9, 4'd12};
    b_slot = 1;
`else
    exp_r = '{4'd9, 4'd3, 4'd12, 4'd3};
    b_slot = 3;
`endif
    for (int k = 0; k < 4; k++) check($sformatf("order_slot%0d_r", k), MESSAGE_SIZE'(slot_r(k)), MESSAGE_SIZE'(exp_r[k]));
    check("order_tie_b", MESSAGE_SIZE'(datagram[SLOT0 + 35*b_slot + 11 +: 10]), MESSAGE_SIZE'(2));
    check("order_slot4_inactive", MESSAGE_SIZE'(datagram[SLOT0 + 35*4]), '0);
    check("order_pulse_count", MESSAGE_SIZE'(pulses), MESSAGE_SIZE'(1));

    // Full list with two extra active records
    rand_scalars();
    drive_cycle(1, 0, 0, '0);
    for (int i = 0; i < SLOTS + 2; i++) drive_cycle(0, 0, 1, rand_rec(1));
    drive_cycle(0, 1, 0, '0);
    idle(3);
    check("full_overflow", MESSAGE_SIZE'(overflow), MESSAGE_SIZE'(1));

    // Transfer coincident with frame_end
    rand_scalars();
    drive_cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, mk(4'($urandom_range(1, 15)), 10'($urandom)));
    drive_cycle(0, 1, 1, mk(4'd0, 10'd7));
    idle(4);
`ifdef DATAGRAM_SORT_EN
    check("edge_slot0_r", MESSAGE_SIZE'(slot_r(0)), '0);
`else
    check("edge_slot3_r", MESSAGE_SIZE'(slot_r(3)), '0);
`endif

    // Random frames
    for (int f = 0; f < 8; f++) begin
      int n;
      bit merge;
      rand_scalars();
      n = $urandom_range(0, SLOTS + 3);
      merge = 1'($urandom);
      drive_cycle(1, 0, 0, '0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) drive_cycle(0, 0, 0, '0);
        drive_cycle(0, merge && (i == n - 1), 1, rand_rec($urandom_range(0, 3) != 0));
      end
      if (!(merge && n > 0)) drive_cycle(0, 1, 0, '0);
      idle(3);
    end

    // Reset in the middle of a frame
    rand_scalars();
    drive_cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, rand_rec(1));
    rst = 1'b0;
    arrivals.delete();
    m_collect = 0;
    m_ovf = 0;
    @(negedge clk);
    check("midrst_datagram", datagram, '0);
    check("midrst_ready", MESSAGE_SIZE'(rec_ready), '0);
    check("midrst_overflow", MESSAGE_SIZE'(overflow), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    check("postrst_datagram", datagram, '0);
    drive_cycle(1, 0, 0, '0);
    drive_cycle(0, 0, 1, mk(4'd5, 10'd3));
    drive_cycle(0, 1, 0, '0);
    idle(4);
    check("postrst_slot0_r", MESSAGE_SIZE'(slot_r(0)), MESSAGE_SIZE'(5));
    check("postrst_slot1_inactive", MESSAGE_SIZE'(datagram[SLOT0 + 35]), '0);

    // Scoreboard scene overlay
    core_state = SCENE_SCOREBOARD;
    scoreboard_data = 12'h5A5;
    @(negedge clk);
    check("scene_not_yet", datagram, last_msg);
    @(posedge clk);
    #1;
    scoreboard_data = 12'h3C3;
    @(negedge clk);
    check("scene_sb_data", MESSAGE_SIZE'(datagram[STATE_SIZE +: SCOREBOARD_DATA_SIZE]), MESSAGE_SIZE'(12'h5A5));
    check("scene_state", MESSAGE_SIZE'(datagram[STATE_SIZE-1:0]), MESSAGE_SIZE'(SCENE_SCOREBOARD));
    check("scene_upper_zero", datagram >> (STATE_SIZE + SCOREBOARD_DATA_SIZE), '0);
    @(posedge clk);
    #1;
    core_state = SCENE_TITLE;
    @(negedge clk);
    check("scene_sb_track", MESSAGE_SIZE'(datagram[STATE_SIZE +: SCOREBOARD_DATA_SIZE]), MESSAGE_SIZE'(12'h3C3));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("scene_frame_kept", datagram, last_msg);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_commits", MESSAGE_SIZE'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datagram_packer.md
DATAGRAM_PACKER -- requirements
Module: datagram_packer

Interface
REQ-001 SHALL have parameter SLOTS, default OBJ_LIMIT: capacity of the alien record list.
REQ-002 SHALL have port clk, input, 1: single system clock; every flop is on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port core_state, input, STATE_SIZE: current scene.
REQ-005 SHALL have ports score and level, input, SCORE_SIZE and LEVEL_SIZE: in-game counters.
REQ-006 SHALL have ports laser_active, laser_r and laser_deg, input, 1, 4 and 9: the laser record.
REQ-007 SHALL have port scoreboard_data, input, SCOREBOARD_DATA_SIZE: pre-packed scoreboard payload.
REQ-008 SHALL have port frame_start, input, 1: pulse that opens a new frame collection.
REQ-009 SHALL have port frame_end, input, 1: pulse that closes the collection and requests a commit.
REQ-010 SHALL have ports rec_valid, input, 1; rec_ready, output, 1; and rec, input, AlienData: the record stream handshake.
REQ-011 SHALL have port datagram, output, MESSAGE_SIZE: the published message.
REQ-012 SHALL have port dgram_update, output, 1: one-cycle pulse when the datagram changes.
REQ-013 SHALL have port overflow, output, 1: sticky flag, meaning at least one active record was refused this frame.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT and COMMIT.
- IDLE: on frame_start, go to COLLECT.
- COLLECT: on frame_end, go to COMMIT.
- COMMIT: always returns to IDLE after 1 cycle.
REQ-015 On frame_start (in any state), SHALL clear the working list, count and overflow, then enter COLLECT; frame_start wins over a simultaneous frame_end.
REQ-016 In COLLECT, rec_ready SHALL be 1 while count<SLOTS; elsewhere rec_ready SHALL be 0.
REQ-017 A transfer SHALL occur when rec_valid&&rec_ready. Records with _active=0 are accepted and discarded.
REQ-018 When count==SLOTS and rec_valid is asserted with rec._active=1, SHALL set overflow; no record is dropped silently without this flag.
REQ-019 Each accepted active record SHALL be inserted into the working list in ascending _r order. Ties keep arrival order (stable sort). Insertion takes 1 cycle; throughput is 1 record per cycle.
REQ-020 A record transferred in the same cycle as frame_end SHALL be included in the commit.
REQ-021 In COMMIT, SHALL copy the working list into the shadow register. Unused slots have _active=0 and all other fields zero.
REQ-022 SHALL pulse dgram_update in the cycle after COMMIT, with datagram already valid in that cycle.
REQ-023 datagram SHALL change only at COMMIT, or when core_state changes (see REQ-026).
REQ-024 Datagram layout, LSB first: state[STATE_SIZE-1:0], then level, then score, then frame_data.
REQ-025 frame_data layout:
- bit 0: laser_active; [4:1]: laser_r; [13:5]: laser_deg.
- Slot k starts at 14+35k, LSB first: active 1, type 2, frame_num 2, r 4, quadrant 2, x_pos 10, y_pos 10, deriv_left 2, deriv_right 2.
REQ-026 When core_state==SCENE_SCOREBOARD, the field following state SHALL be scoreboard_data, registered each cycle. Upper bits are zero.
REQ-027 Score, level and laser fields SHALL be sampled at COMMIT only. core_state SHALL be registered every cycle.

Reset
REQ-028 While rst=0, SHALL hold the FSM in IDLE, count=0, datagram=0, dgram_update=0, rec_ready=0, overflow=0 and all list entries inactive.
REQ-029 Reset asserted mid-COLLECT SHALL discard the partial list; no commit follows reset release until a new frame_start/frame_end pair.

Configuration
REQ-030 With DATAGRAM_SORT_EN defined, insertion SHALL be sorted per REQ-019. Without it, records SHALL be appended in arrival order; all other behaviour is identical.

Structure
REQ-031 The AlienData typedef, the field widths, MESSAGE_SIZE, the SCENE_* values and OBJ_LIMIT SHALL live in the shared constants/typedefs package; none are redefined locally.
REQ-032 The list SHALL be a sub-module sorted_insert_list. It provides clear, insert and a parallel read of all entries, and handles the compare/shift logic.

Verification
REQ-033 Sort order: frame_start; send r=9, 3, 12, 3(B); frame_end -> slots 0..3 hold r=3, 3(B), 9, 12 and slots 4..SLOTS-1 are inactive; dgram_update pulses once.
REQ-034 Full list: send SLOTS+2 active records back-to-back -> rec_ready drops after SLOTS transfers, overflow=1, and the datagram holds SLOTS records.
REQ-035 Same-cycle edge: a transfer with r=0 in the frame_end cycle -> that record appears in slot 0 of the commit.
REQ-036 Reset mid-frame: rst=0 after 3 records, release, then frame_start with 1 record r=5 and frame_end -> datagram shows only r=5; before the commit, datagram=0.
REQ-037 Scene switch: core_state=SCENE_SCOREBOARD with scoreboard_data=0x5A5 -> the bits after state read 0x5A5 one cycle later; with no frame pulses, the frame_data copy stays unchanged.
REQ-038 Unsorted build: without DATAGRAM_SORT_EN, repeat the REQ-033 stimulus -> slots hold r=9, 3, 12, 3(B).
